riscv_trap_ctrl: RTL and testbench

RISCV_TRAP_CTRL -- requirements
Module: riscv_trap_ctrl

---
 rtl/riscv_trap_pkg.sv | 15 +
 rtl/riscv_trap_prio_enc.sv | 20 ++
 rtl/riscv_trap_ctrl.sv | 107 ++++++++++
 tb/tb_riscv_trap_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/riscv_trap_pkg.sv
// Shared definitions for the trap controller: FSM encoding and exception cause codes.
package riscv_trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_RET   = 2'd2,
    ST_DRAIN = 2'd3
  } trap_state_e;

  localparam logic [63:0] CAUSE_INST_MISALIGNED  = 64'd0;
  localparam logic [63:0] CAUSE_LOAD_MISALIGNED  = 64'd4;
  localparam logic [63:0] CAUSE_STORE_MISALIGNED = 64'd6;

endpackage

// File: rtl/riscv_trap_prio_enc.sv
// Fixed-priority encoder: instruction > load > store misaligned.
module riscv_trap_prio_enc
  import riscv_trap_pkg::*;
(
  input  logic        inst_misaligned,
  input  logic        load_misaligned,
  input  logic        store_misaligned,
  output logic        exc_present,
  output logic [63:0] cause
);

  always_comb begin
    exc_present = inst_misaligned | load_misaligned | store_misaligned;
    cause       = '0;
    if (inst_misaligned)       cause = CAUSE_INST_MISALIGNED;
    else if (load_misaligned)  cause = CAUSE_LOAD_MISALIGNED;
    else if (store_misaligned) cause = CAUSE_STORE_MISALIGNED;
  end

endmodule

// File: rtl/riscv_trap_ctrl.sv
// Trap/MRET sequencer: captures mepc/mcause/mtval, redirects the PC, then drains the front end.
module riscv_trap_ctrl
  import riscv_trap_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        i_riscv_trap_clk,
  input  logic        i_riscv_trap_rst,
  input  logic        i_riscv_trap_valid,
  input  logic        i_riscv_trap_inst_addr_misaligned,
  input  logic        i_riscv_trap_load_addr_misaligned,
  input  logic        i_riscv_trap_store_addr_misaligned,
  input  logic [63:0] i_riscv_trap_pc,
  input  logic [63:0] i_riscv_trap_icu_result,
  input  logic        i_riscv_trap_mret,
  input  logic [63:0] i_riscv_trap_mtvec,
  output logic        o_riscv_trap_flush,
  output logic        o_riscv_trap_redirect,
  output logic [63:0] o_riscv_trap_redirect_pc,
  output logic        o_riscv_trap_stall,
  output logic [63:0] o_riscv_trap_mepc,
  output logic [63:0] o_riscv_trap_mcause,
  output logic [63:0] o_riscv_trap_mtval
);

  trap_state_e state_q, state_d;
  logic [2:0]  cnt_q;
  logic        exc_present;
  logic [63:0] exc_cause;
  logic        take_exc;
  logic        take_mret;
  logic        unused_bits;

  assign unused_bits = ^{i_riscv_trap_pc[0], i_riscv_trap_mtvec[1:0]};

  riscv_trap_prio_enc u_prio_enc (
    .inst_misaligned  (i_riscv_trap_inst_addr_misaligned),
    .load_misaligned  (i_riscv_trap_load_addr_misaligned),
    .store_misaligned (i_riscv_trap_store_addr_misaligned),
    .exc_present      (exc_present),
    .cause            (exc_cause)
  );

  // Exception beats MRET in the same cycle.
  assign take_exc  = (state_q == ST_IDLE) && i_riscv_trap_valid && exc_present;
  assign take_mret = (state_q == ST_IDLE) && i_riscv_trap_valid && i_riscv_trap_mret && !exc_present;

  always_ff @(posedge i_riscv_trap_clk) begin
    if (i_riscv_trap_rst) state_q <= ST_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_exc)       state_d = ST_TRAP;
        else if (take_mret) state_d = ST_RET;
      end
      ST_TRAP:  state_d = ST_DRAIN;
      ST_RET:   state_d = ST_IDLE;
      ST_DRAIN: if (cnt_q == 3'd0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counter is preloaded in TRAP so DRAIN lasts exactly DRAIN_CYCLES cycles.
  always_ff @(posedge i_riscv_trap_clk) begin
    if (i_riscv_trap_rst) begin
      cnt_q             <= '0;
      o_riscv_trap_mepc   <= '0;
      o_riscv_trap_mcause <= '0;
      o_riscv_trap_mtval  <= '0;
    end else begin
      if (state_q == ST_TRAP)                        cnt_q <= 3'(DRAIN_CYCLES - 1);
      else if (state_q == ST_DRAIN && cnt_q != 3'd0) cnt_q <= cnt_q - 3'd1;
      if (take_exc) begin
        o_riscv_trap_mepc   <= {i_riscv_trap_pc[63:1], 1'b0};
        o_riscv_trap_mcause <= exc_cause;
        o_riscv_trap_mtval  <= i_riscv_trap_icu_result;
      end
    end
  end

  always_comb begin
    o_riscv_trap_flush       = 1'b0;
    o_riscv_trap_redirect    = 1'b0;
    o_riscv_trap_redirect_pc = '0;
    o_riscv_trap_stall       = 1'b0;
    case (state_q)
      ST_TRAP: begin
        o_riscv_trap_flush       = 1'b1;
        o_riscv_trap_redirect    = 1'b1;
        o_riscv_trap_redirect_pc = {i_riscv_trap_mtvec[63:2], 2'b00};
        o_riscv_trap_stall       = 1'b1;
      end
      ST_RET: begin
        o_riscv_trap_flush       = 1'b1;
        o_riscv_trap_redirect    = 1'b1;
        o_riscv_trap_redirect_pc = o_riscv_trap_mepc;
      end
      ST_DRAIN: o_riscv_trap_stall = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_riscv_trap_ctrl.sv
// Directed bench for riscv_trap_ctrl with hand-computed expectations.
module tb_riscv_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, inst_f, load_f, store_f, mret;
  logic [63:0] pc, icu, mtvec;
  logic        flush, redirect, stall;
  logic [63:0] redirect_pc, mepc, mcause, mtval;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_trap_ctrl #(.DRAIN_CYCLES(2)) dut (
    .i_riscv_trap_clk                   (clk),
    .i_riscv_trap_rst                   (rst),
    .i_riscv_trap_valid                 (valid),
    .i_riscv_trap_inst_addr_misaligned  (inst_f),
    .i_riscv_trap_load_addr_misaligned  (load_f),
    .i_riscv_trap_store_addr_misaligned (store_f),
    .i_riscv_trap_pc                    (pc),
    .i_riscv_trap_icu_result            (icu),
    .i_riscv_trap_mret                  (mret),
    .i_riscv_trap_mtvec                 (mtvec),
    .o_riscv_trap_flush                 (flush),
    .o_riscv_trap_redirect              (redirect),
    .o_riscv_trap_redirect_pc           (redirect_pc),
    .o_riscv_trap_stall                 (stall),
    .o_riscv_trap_mepc                  (mepc),
    .o_riscv_trap_mcause                (mcause),
    .o_riscv_trap_mtval                 (mtval)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    valid = 0; inst_f = 0; load_f = 0; store_f = 0; mret = 0;
  endtask

  task automatic chk_ctl(input string tag, input logic f, input logic r, input logic s,
                         input logic [63:0] rpc);
    chk({tag, ".flush"}, 64'(flush), 64'(f));
    chk({tag, ".redirect"}, 64'(redirect), 64'(r));
    chk({tag, ".stall"}, 64'(stall), 64'(s));
    chk({tag, ".rpc"}, redirect_pc, rpc);
  endtask

  task automatic chk_csr(input string tag, input logic [63:0] e, input logic [63:0] c,
                         input logic [63:0] v);
    chk({tag, ".mepc"}, mepc, e);
    chk({tag, ".mcause"}, mcause, c);
    chk({tag, ".mtval"}, mtval, v);
  endtask

  initial begin
    rst = 1; clear_in();
    pc = '0; icu = '0; mtvec = 64'h8000_0001;
    step(); step();
    chk_ctl("rst", 0, 0, 0, 64'h0);
    chk_csr("rst", 64'h0, 64'h0, 64'h0);

    // Load misaligned trap, then a store flag during drain that must be ignored
    rst = 0;
    valid = 1; load_f = 1; pc = 64'h1000; icu = 64'h2003;
    #1;
    chk("accept_cycle.flush", 64'(flush), 64'h0);
    step();
    chk_ctl("trap", 1, 1, 1, 64'h8000_0000);
    chk_csr("trap", 64'h1000, 64'h4, 64'h2003);
    load_f = 0; store_f = 1; icu = 64'h55;
    step();
    chk_ctl("drain1", 0, 0, 1, 64'h0);
    step();
    chk_ctl("drain2", 0, 0, 1, 64'h0);
    chk_csr("drain2", 64'h1000, 64'h4, 64'h2003);
    clear_in();
    step();
    chk_ctl("idle_after_drain", 0, 0, 0, 64'h0);

    // MRET returns to the saved mepc with no stall
    valid = 1; mret = 1;
    step();
    chk_ctl("ret", 1, 1, 0, 64'h1000);
    clear_in();
    step();
    chk_ctl("idle_after_ret", 0, 0, 0, 64'h0);
    chk_csr("idle_after_ret", 64'h1000, 64'h4, 64'h2003);

    // Simultaneous inst+store: inst wins; pc[0] cleared
    valid = 1; inst_f = 1; store_f = 1; pc = 64'h1001; icu = 64'h3000;
    step();
    chk_ctl("prio_trap", 1, 1, 1, 64'h8000_0000);
    chk_csr("prio", 64'h1000, 64'h0, 64'h3000);
    clear_in();
    step();
    chk_ctl("prio_drain1", 0, 0, 1, 64'h0);

    // Reset in first drain cycle, new exception accepted right after release
    rst = 1;
    step();
    chk_ctl("rst_mid", 0, 0, 0, 64'h0);
    chk_csr("rst_mid", 64'h0, 64'h0, 64'h0);
    rst = 0; valid = 1; load_f = 1; pc = 64'h2000; icu = 64'h4;
    step();
    chk_ctl("post_rst_trap", 1, 1, 1, 64'h8000_0000);
    chk_csr("post_rst", 64'h2000, 64'h4, 64'h4);
    clear_in();
    step(); step();
    chk("post_rst_drain2.stall", 64'(stall), 64'h1);
    step();
    chk("post_rst_idle.stall", 64'(stall), 64'h0);

    // valid=0 with everything asserted is ignored
    valid = 0; inst_f = 1; load_f = 1; store_f = 1; mret = 1; pc = 64'h7777; icu = 64'h9999;
    step();
    chk_ctl("invalid", 0, 0, 0, 64'h0);
    chk_csr("invalid", 64'h2000, 64'h4, 64'h4);
    clear_in();

    // Exception and MRET together: exception wins and overwrites mepc
    valid = 1; mret = 1; store_f = 1; pc = 64'h3004; icu = 64'h11; mtvec = 64'h0000_0000_4000_0007;
    step();
    chk_ctl("exc_mret", 1, 1, 1, 64'h4000_0004);
    chk_csr("exc_mret", 64'h3004, 64'h6, 64'h11);
    clear_in();
    step(); step(); step();
    chk_ctl("final_idle", 0, 0, 0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
